// File: rtl/reg_dump_reader.sv
// Debug read-out engine: stalls the core, walks the register file through
// read port 1 and streams every register out on a valid/ready port.
module reg_dump_reader #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              hold_req,
  input  logic              hold_ack,
  output logic [REG_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [REG_W-1:0]  dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [REG_W-1:0] LAST_IDX = REG_W'(NUM_REGS - 1);

  logic [2:0]        state_q, state_d;
  logic [REG_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic in_xfer;
  logic abort_w;
  logic is_last;
  logic sending;

  assign in_xfer = (state_q == S_READ) || (state_q == S_SEND);
  // Losing the stall mid-dump wins over everything, including a handshake.
  assign abort_w = in_xfer && !hold_ack;
  assign is_last = (index_q == LAST_IDX);
  assign sending = (state_q == S_SEND) && !abort_w;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HOLD;
          index_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_ack) state_d = S_READ;
      end
      S_READ: begin
        data_d  = rd_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dump_ready) begin
          if (is_last) begin
            state_d = S_FIN;
          end else begin
            index_d = index_q + REG_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        index_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        index_d = '0;
      end
    endcase
    if (abort_w) begin
      state_d = S_IDLE;
      index_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign hold_req   = ((state_q == S_HOLD) || in_xfer) && !abort_w;
  assign rd_addr    = (in_xfer && !abort_w) ? index_q : '0;
  assign dump_valid = sending;
  assign dump_data  = sending ? data_q : '0;
  assign dump_index = sending ? index_q : '0;
  assign dump_last  = sending && is_last;
  assign busy       = (state_q != S_IDLE) && !abort_w;
  assign done       = (state_q == S_FIN);
  assign abort      = abort_w;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dump, backpressure, hold wait,
// abort, reset mid-dump, and a 4-register build that ignores start while busy.
module tb_reg_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [32];

  // Full-size instance
  logic        rst_n, start, hold_ack, dump_ready;
  logic        hold_req, dump_valid, dump_last, busy, done, abort;
  logic [4:0]  rd_addr, dump_index;
  logic [31:0] rd_data, dump_data;

  // NUM_REGS=4 instance
  logic        start4, hold_ack4, dump_ready4;
  logic        hold_req4, dump_valid4, dump_last4, busy4, done4, abort4;
  logic [4:0]  rd_addr4, dump_index4;
  logic [31:0] rd_data4, dump_data4;

  assign rd_data  = regs[rd_addr];
  assign rd_data4 = regs[rd_addr4];

  reg_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold_req(hold_req),
    .hold_ack(hold_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_index(dump_index), .dump_last(dump_last), .busy(busy),
    .done(done), .abort(abort)
  );

  reg_dump_reader #(.NUM_REGS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .hold_req(hold_req4),
    .hold_ack(hold_ack4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .dump_valid(dump_valid4), .dump_ready(dump_ready4), .dump_data(dump_data4),
    .dump_index(dump_index4), .dump_last(dump_last4), .busy(busy4),
    .done(done4), .abort(abort4)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int cyc_start = 0;

  int          nb;
  logic [4:0]  b_idx  [64];
  logic [31:0] b_data [64];
  logic        b_last [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] outs_no_abort();
    return {16'd0, hold_req, rd_addr, dump_valid, dump_data, dump_index,
            dump_last, busy, done};
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    return (i == 0) ? 32'd0 : 32'h100 + i;
  endfunction

  // Drives dump_ready / hold_ack from the current sample point until done or abort.
  task automatic collect(input int stall_idx, input int stall_len, input int drop_idx,
                         input int budget, output int done_at, output bit aborted);
    int stalled;
    logic [31:0] saved;
    nb = 0; stalled = 0; done_at = -1; aborted = 1'b0; saved = '0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        done_at = cyc - cyc_start;
        step();
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);
        return;
      end
      if (dump_valid) begin
        if (int'(dump_index) == drop_idx) begin
          hold_ack = 1'b0;
          #1;
          check("abort_pulse", {63'd0, abort}, 64'd1);
          check("abort_outputs_zero", outs_no_abort(), 64'd0);
          step();
          check("abort_one_cycle", {63'd0, abort}, 64'd0);
          check("idle_after_abort", {63'd0, busy}, 64'd0);
          hold_ack = 1'b1;
          aborted = 1'b1;
          return;
        end
        if (int'(dump_index) == stall_idx && stalled < stall_len) begin
          if (stalled == 0) saved = dump_data;
          else check("stall_data_stable", {32'd0, dump_data}, {32'd0, saved});
          stalled++;
          dump_ready = 1'b0;
        end else begin
          if (int'(dump_index) == stall_idx && stalled > 0)
            check("stall_accept_data", {32'd0, dump_data}, {32'd0, saved});
          dump_ready = 1'b1;
          b_idx[nb] = dump_index; b_data[nb] = dump_data; b_last[nb] = dump_last;
          nb++;
        end
      end else begin
        dump_ready = 1'b1;
      end
      step();
    end
    check("timeout", 64'd0, 64'd1);
  endtask

  task automatic verify_beats(input string tag, input int n_exp, input int num_regs);
    check({tag, "_beats"}, 64'(nb), 64'(n_exp));
    for (int i = 0; i < nb && i < n_exp; i++) begin
      check({tag, "_idx"},  {59'd0, b_idx[i]},  64'(i));
      check({tag, "_data"}, {32'd0, b_data[i]}, {32'd0, exp_data(i)});
      check({tag, "_last"}, {63'd0, b_last[i]}, {63'd0, (i == num_regs - 1)});
    end
  endtask

  task automatic kick();
    start = 1'b1;
    cyc_start = cyc;
    step();
    start = 1'b0;
  endtask

  initial begin
    int  done_at;
    bit  aborted;
    int  done4_at;
    int  done4_cnt;

    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h100 + i;
    rst_n = 1'b0; start = 1'b0; hold_ack = 1'b1; dump_ready = 1'b1;
    start4 = 1'b0; hold_ack4 = 1'b1; dump_ready4 = 1'b1;
    step(); step();
    check("reset_outputs", outs_no_abort(), 64'd0);
    check("reset_abort", {63'd0, abort}, 64'd0);
    rst_n = 1'b1;
    step();

    // Full dump, ready tied high
    kick();
    check("hold_state", {62'd0, hold_req, busy}, 64'd3);
    collect(-1, 0, -1, 200, done_at, aborted);
    verify_beats("full", 32, 32);
    check("full_done_latency", 64'(done_at), 64'd66);
    $display("[TB] full dump: %0d beats, done at +%0d", nb, done_at);

    // Backpressure on index 7
    kick();
    collect(7, 5, -1, 200, done_at, aborted);
    verify_beats("bp", 32, 32);
    check("bp_done_latency", 64'(done_at), 64'd71);
    $display("[TB] backpressure dump: %0d beats, done at +%0d", nb, done_at);

    // Hold wait: ack withheld for 10 cycles
    hold_ack = 1'b0;
    kick();
    for (int k = 0; k < 10; k++) begin
      check("hold_wait_state", {62'd0, hold_req, busy}, 64'd3);
      check("hold_wait_rdaddr", {59'd0, rd_addr}, 64'd0);
      check("hold_wait_valid", {63'd0, dump_valid}, 64'd0);
      if (k < 9) step();
    end
    hold_ack = 1'b1;
    step();
    check("ack_plus1_valid", {63'd0, dump_valid}, 64'd0);
    step();
    check("ack_plus2_valid", {63'd0, dump_valid}, 64'd1);
    check("ack_plus2_index", {59'd0, dump_index}, 64'd0);
    collect(-1, 0, -1, 200, done_at, aborted);
    verify_beats("holdwait", 32, 32);
    $display("[TB] hold-wait dump: %0d beats after ack", nb);

    // Abort at index 12, then restart from 0
    kick();
    collect(-1, 0, 12, 200, done_at, aborted);
    check("abort_seen", {63'd0, aborted}, 64'd1);
    verify_beats("abort", 12, 32);
    $display("[TB] aborted dump: %0d beats before abort", nb);
    kick();
    collect(-1, 0, -1, 200, done_at, aborted);
    verify_beats("restart", 32, 32);
    check("restart_done_latency", 64'(done_at), 64'd66);
    $display("[TB] restart dump: %0d beats, done at +%0d", nb, done_at);

    // Reset while in SEND
    kick();
    step(); step(); step(); step();
    check("pre_reset_send", {63'd0, dump_valid}, 64'd1);
    rst_n = 1'b0;
    step(); step();
    check("midreset_outputs", outs_no_abort(), 64'd0);
    check("midreset_abort", {63'd0, abort}, 64'd0);
    rst_n = 1'b1;
    step();
    check("post_reset_outputs", outs_no_abort(), 64'd0);
    check("post_reset_abort", {63'd0, abort}, 64'd0);
    $display("[TB] reset mid-dump: outputs cleared");

    // NUM_REGS=4 build with start held high while busy
    nb = 0; done4_at = -1; done4_cnt = 0;
    start4 = 1'b1;
    cyc_start = cyc;
    step();
    for (int k = 1; k < 20; k++) begin
      if (dump_valid4) begin
        b_idx[nb] = dump_index4; b_data[nb] = dump_data4; b_last[nb] = dump_last4;
        nb++;
      end
      if (done4) begin
        done4_cnt++;
        if (done4_at < 0) done4_at = cyc - cyc_start;
      end
      start4 = (k < 8);
      step();
    end
    verify_beats("n4", 4, 4);
    check("n4_done_latency", 64'(done4_at), 64'd10);
    check("n4_done_count", 64'(done4_cnt), 64'd1);
    check("n4_idle_end", {63'd0, busy4}, 64'd0);
    $display("[TB] NUM_REGS=4 dump: %0d beats, done at +%0d", nb, done4_at);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
